// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage with iterative RV32M multiplier (divider when EX_DIV_EN is defined)
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ID_valid,
  input  logic [XLEN-1:0] ID_instr,
  input  logic [XLEN-1:0] ID_pc,
  input  logic [XLEN-1:0] ID_r1,
  input  logic [XLEN-1:0] ID_r2,
  input  logic [XLEN-1:0] ID_imm,
  input  logic [4:0]      ID_rd,
  input  logic [6:0]      ID_opcode,
  input  logic            ID_regwrite,
  output logic            ex_stall,
  output logic [XLEN-1:0] EX_instr,
  output logic [4:0]      EX_rd,
  output logic [6:0]      EX_opcode,
  output logic            EX_regwrite,
  output logic [XLEN-1:0] EX_alu_result,
  output logic [XLEN-1:0] EX_r2,
  output logic [1:0]      data_cache_index,
  output logic [27:0]     data_cache_tag_addr
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_mext, muldiv;
  logic            signed_a, signed_b, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  logic [CW-1:0]   count;
  logic [31:0]     h_instr, h_r2;
  logic [4:0]      h_rd;
  logic [6:0]      h_opcode;
  logic            h_rw, h_neg;
  logic [2:0]      h_funct3;
  logic [63:0]     acc, mcand;
  logic [31:0]     opb;
`ifdef EX_DIV_EN
  logic            h_sign_a, h_div_zero;
  logic [33:0]     div_sub;
  logic [31:0]     div_q, div_r;
`endif

  logic            alu_ok, alu_rw;
  logic [31:0]     alu_res, op_b;
  logic [4:0]      shamt;
  logic [63:0]     prod;
  logic [31:0]     fin_res;

  logic [31:0]     nx_instr, nx_res, nx_r2;
  logic [4:0]      nx_rd;
  logic [6:0]      nx_opcode;
  logic            nx_rw;

  assign funct3  = ID_instr[14:12];
  assign funct7  = ID_instr[31:25];
  assign is_mext = ID_valid && (ID_opcode == OP_R) && (funct7 == 7'b0000001);
`ifdef EX_DIV_EN
  assign muldiv  = is_mext;
`else
  assign muldiv  = is_mext && !funct3[2];
`endif

  // MULHU/DIVU/REMU treat both operands unsigned; MULHSU only rs2
  assign signed_a = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign signed_b = funct3[2] ? !funct3[0] : !funct3[1];
  assign sa       = signed_a & ID_r1[31];
  assign sb       = signed_b & ID_r2[31];
  assign mag_a    = sa ? -ID_r1 : ID_r1;
  assign mag_b    = sb ? -ID_r2 : ID_r2;

  assign ex_stall = !reset && ((state != IDLE && state != DONE) || (state == IDLE && muldiv));

  always_comb begin
    alu_ok  = 1'b0;
    alu_res = '0;
    alu_rw  = ID_regwrite;
    op_b    = (ID_opcode == OP_R) ? ID_r2 : ID_imm;
    shamt   = op_b[4:0];
    if (ID_valid) begin
      case (ID_opcode)
        OP_R, OP_I: begin
          alu_ok = 1'b1;
          if (ID_opcode == OP_R && funct7 == 7'b0000001) begin
            alu_res = '0;
          end else begin
            case (funct3)
              3'b000: begin
                if (ID_opcode == OP_R && ID_instr[30]) alu_res = ID_r1 - op_b;
                else                                   alu_res = ID_r1 + op_b;
              end
              3'b001: alu_res = ID_r1 << shamt;
              3'b010: alu_res = {31'd0, $signed(ID_r1) < $signed(op_b)};
              3'b011: alu_res = {31'd0, ID_r1 < op_b};
              3'b100: alu_res = ID_r1 ^ op_b;
              3'b101: begin
                if (ID_instr[30]) alu_res = $unsigned($signed(ID_r1) >>> shamt);
                else              alu_res = ID_r1 >> shamt;
              end
              3'b110: alu_res = ID_r1 | op_b;
              default: alu_res = ID_r1 & op_b;
            endcase
          end
        end
        OP_LOAD, OP_STORE: begin alu_ok = 1'b1; alu_res = ID_r1 + ID_imm; end
        OP_LUI:            begin alu_ok = 1'b1; alu_res = ID_imm; end
        OP_AUIPC:          begin alu_ok = 1'b1; alu_res = ID_pc + ID_imm; end
        OP_JAL, OP_JALR:   begin alu_ok = 1'b1; alu_res = ID_pc + 32'd4; end
        OP_BRANCH:         begin alu_ok = 1'b1; alu_rw = 1'b0; end
        default: ;
      endcase
    end
  end

  // Sign correction of the held magnitude result, consumed in DONE
  always_comb begin
    prod = h_neg ? -acc : acc;
`ifdef EX_DIV_EN
    div_sub = {1'b0, acc[63:31]} - {2'b00, opb};
    div_q   = h_div_zero ? 32'hFFFF_FFFF : (h_neg ? -acc[31:0] : acc[31:0]);
    div_r   = h_sign_a ? -acc[63:32] : acc[63:32];
`endif
    case (h_funct3)
      3'b000:                 fin_res = prod[31:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[63:32];
`ifdef EX_DIV_EN
      default:                fin_res = h_funct3[1] ? div_r : div_q;
`else
      default:                fin_res = 32'd0;
`endif
    endcase
  end

  always_comb begin
    nx_instr  = '0;
    nx_rd     = '0;
    nx_opcode = '0;
    nx_rw     = 1'b0;
    nx_res    = '0;
    nx_r2     = '0;
    if (state == DONE) begin
      nx_instr  = h_instr;
      nx_rd     = h_rd;
      nx_opcode = h_opcode;
      nx_rw     = h_rw;
      nx_res    = fin_res;
      nx_r2     = h_r2;
    end else if (state == IDLE && !muldiv && alu_ok) begin
      nx_instr  = ID_instr;
      nx_rd     = ID_rd;
      nx_opcode = ID_opcode;
      nx_rw     = alu_rw;
      nx_res    = alu_res;
      nx_r2     = ID_r2;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (muldiv) state_next = BUSY;
      BUSY:    if (count == CW'(MUL_CYCLES - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_instr      <= '0;
      EX_rd         <= '0;
      EX_opcode     <= '0;
      EX_regwrite   <= 1'b0;
      EX_alu_result <= '0;
      EX_r2         <= '0;
      count         <= '0;
      h_instr       <= '0;
      h_rd          <= '0;
      h_opcode      <= '0;
      h_rw          <= 1'b0;
      h_r2          <= '0;
      h_funct3      <= '0;
      h_neg         <= 1'b0;
      acc           <= '0;
      mcand         <= '0;
      opb           <= '0;
`ifdef EX_DIV_EN
      h_sign_a      <= 1'b0;
      h_div_zero    <= 1'b0;
`endif
    end else begin
      EX_instr      <= nx_instr;
      EX_rd         <= nx_rd;
      EX_opcode     <= nx_opcode;
      EX_regwrite   <= nx_rw;
      EX_alu_result <= nx_res;
      EX_r2         <= nx_r2;
      case (state)
        IDLE: begin
          if (muldiv) begin
            count    <= '0;
            h_instr  <= ID_instr;
            h_rd     <= ID_rd;
            h_opcode <= ID_opcode;
            h_rw     <= ID_regwrite;
            h_r2     <= ID_r2;
            h_funct3 <= funct3;
            h_neg    <= sa ^ sb;
            mcand    <= {32'd0, mag_a};
            opb      <= mag_b;
`ifdef EX_DIV_EN
            h_sign_a   <= sa;
            h_div_zero <= (ID_r2 == 32'd0);
            acc        <= funct3[2] ? {32'd0, mag_a} : 64'd0;
`else
            acc        <= 64'd0;
`endif
          end
        end
        BUSY: begin
          count <= count + CW'(1);
`ifdef EX_DIV_EN
          // Restoring step: acc holds {remainder, dividend/quotient bits}
          if (h_funct3[2]) begin
            if (!div_sub[33]) acc <= {div_sub[31:0], acc[30:0], 1'b1};
            else              acc <= {acc[62:0], 1'b0};
          end else
`endif
          begin
            if (opb[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_cache_index    = EX_alu_result[3:2];
  assign data_cache_tag_addr = EX_alu_result[31:4];
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;
  logic        clk, reset;
  logic        ID_valid, ID_regwrite;
  logic [31:0] ID_instr, ID_pc, ID_r1, ID_r2, ID_imm;
  logic [4:0]  ID_rd;
  logic [6:0]  ID_opcode;
  logic        ex_stall, EX_regwrite;
  logic [31:0] EX_instr, EX_alu_result, EX_r2;
  logic [4:0]  EX_rd;
  logic [6:0]  EX_opcode;
  logic [1:0]  data_cache_index;
  logic [27:0] data_cache_tag_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_instr, exp_res, exp_r2;
  logic [4:0]  exp_rd;
  logic [6:0]  exp_opcode;
  logic        exp_rw;
  int          exp_stall;

  ex_stage dut (
    .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_instr(ID_instr), .ID_pc(ID_pc),
    .ID_r1(ID_r1), .ID_r2(ID_r2), .ID_imm(ID_imm), .ID_rd(ID_rd), .ID_opcode(ID_opcode),
    .ID_regwrite(ID_regwrite), .ex_stall(ex_stall), .EX_instr(EX_instr), .EX_rd(EX_rd),
    .EX_opcode(EX_opcode), .EX_regwrite(EX_regwrite), .EX_alu_result(EX_alu_result),
    .EX_r2(EX_r2), .data_cache_index(data_cache_index), .data_cache_tag_addr(data_cache_tag_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    logic [9:0] rs = 10'($urandom);
    logic [4:0] rd = 5'($urandom);
    return {f7, rs, f3, rd, op};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Reference: RV32IM semantics with full-width arithmetic
  task automatic model(input logic v, input logic [31:0] instr, pc, a, b, imm, input logic rw);
    logic [6:0]  op = instr[6:0];
    logic [2:0]  f3 = instr[14:12];
    logic [6:0]  f7 = instr[31:25];
    logic        known = 1'b1;
    logic [31:0] res = 32'd0;
    logic        wr = rw;
    logic [31:0] opnd;
    logic [63:0] a_s = {{32{a[31]}}, a};
    logic [63:0] a_u = {32'd0, a};
    logic [63:0] b_s = {{32{b[31]}}, b};
    logic [63:0] b_u = {32'd0, b};
    logic [63:0] p;
    logic signed [31:0] sa_v = a;
    logic signed [31:0] sb_v = b;
    logic signed [31:0] sres;
    exp_stall = 0;
    opnd = (op == 7'h33) ? b : imm;
    if (!v) known = 1'b0;
    else case (op)
      7'h33, 7'h13: begin
        if (op == 7'h33 && f7 == 7'h01) begin
          if (!f3[2]) exp_stall = 33;
          case (f3)
            3'd0: res = a * b;
            3'd1: begin p = a_s * b_s; res = p[63:32]; end
            3'd2: begin p = a_s * b_u; res = p[63:32]; end
            3'd3: begin p = a_u * b_u; res = p[63:32]; end
            default: begin
`ifdef EX_DIV_EN
              exp_stall = 33;
              if (f3 == 3'd4) begin
                if (b == 0) res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
                else begin sres = sa_v / sb_v; res = sres; end
              end else if (f3 == 3'd5) begin
                res = (b == 0) ? 32'hFFFF_FFFF : a / b;
              end else if (f3 == 3'd6) begin
                if (b == 0) res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 0;
                else begin sres = sa_v % sb_v; res = sres; end
              end else begin
                res = (b == 0) ? a : a % b;
              end
`else
              res = 32'd0;
`endif
            end
          endcase
        end else begin
          case (f3)
            3'd0: res = (op == 7'h33 && instr[30]) ? a - opnd : a + opnd;
            3'd1: res = a << opnd[4:0];
            3'd2: res = ($signed(a) < $signed(opnd)) ? 32'd1 : 32'd0;
            3'd3: res = (a < opnd) ? 32'd1 : 32'd0;
            3'd4: res = a ^ opnd;
            3'd5: begin
              if (instr[30]) begin sres = sa_v >>> opnd[4:0]; res = sres; end
              else res = a >> opnd[4:0];
            end
            3'd6: res = a | opnd;
            default: res = a & opnd;
          endcase
        end
      end
      7'h03, 7'h23: res = a + imm;
      7'h37:        res = imm;
      7'h17:        res = pc + imm;
      7'h6F, 7'h67: res = pc + 4;
      7'h63:        begin res = 0; wr = 1'b0; end
      default:      known = 1'b0;
    endcase
    exp_instr  = known ? instr : 32'd0;
    exp_rd     = known ? instr[11:7] : 5'd0;
    exp_opcode = known ? op : 7'd0;
    exp_rw     = known ? wr : 1'b0;
    exp_res    = known ? res : 32'd0;
    exp_r2     = known ? b : 32'd0;
  endtask

  task automatic present(input logic v, input logic [31:0] instr, pc, a, b, imm, input logic rw);
    ID_valid = v; ID_instr = instr; ID_pc = pc; ID_r1 = a; ID_r2 = b; ID_imm = imm;
    ID_rd = instr[11:7]; ID_opcode = instr[6:0]; ID_regwrite = rw;
  endtask

  task automatic run_op(input string name, input logic v, input logic [31:0] instr, pc, a, b, imm,
                        input logic rw);
    int   stalls = 0;
    logic bub = 1'b1;
    @(negedge clk);
    present(v, instr, pc, a, b, imm, rw);
    model(v, instr, pc, a, b, imm, rw);
    #1;
    while (ex_stall && stalls < 60) begin
      @(posedge clk); #2;
      stalls++;
      if (EX_instr != 0 || EX_rd != 0 || EX_opcode != 0 || EX_regwrite || EX_alu_result != 0 || EX_r2 != 0)
        bub = 1'b0;
    end
    @(posedge clk); #2;
    check({name, ".stall_cycles"}, 64'(stalls), 64'(exp_stall));
    if (stalls > 0) check({name, ".bubbles"}, 64'(bub), 64'd1);
    check({name, ".instr"},    64'(EX_instr),      64'(exp_instr));
    check({name, ".rd"},       64'(EX_rd),         64'(exp_rd));
    check({name, ".opcode"},   64'(EX_opcode),     64'(exp_opcode));
    check({name, ".regwrite"}, 64'(EX_regwrite),   64'(exp_rw));
    check({name, ".result"},   64'(EX_alu_result), 64'(exp_res));
    check({name, ".r2"},       64'(EX_r2),         64'(exp_r2));
    check({name, ".index"},    64'(data_cache_index),    64'(exp_res[3:2]));
    check({name, ".tag"},      64'(data_cache_tag_addr), 64'(exp_res[31:4]));
  endtask

  initial begin
    reset = 1'b1;
    present(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("reset.result", 64'(EX_alu_result), 64'd0);
    check("reset.instr",  64'(EX_instr),      64'd0);
    check("reset.stall",  64'(ex_stall),      64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("add",    1'b1, mk(7'h00, 3'd0, 7'h33), 32'h100, 32'd5, 32'd7, 32'd0, 1'b1);
    check("add.expect12", 64'(EX_alu_result), 64'd12);
    run_op("sw",     1'b1, mk(7'h00, 3'd2, 7'h23), 32'h104, 32'h0000_1234, 32'h0000_ABCD, 32'h8, 1'b0);
    check("sw.index3", 64'(data_cache_index), 64'd3);
    check("sw.tag", 64'(data_cache_tag_addr), 64'h0000123);
    run_op("mul",    1'b1, mk(7'h01, 3'd0, 7'h33), 32'h108, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b1);
    check("mul.expectEB", 64'(EX_alu_result), 64'hFFFF_FFEB);
    run_op("mulhu",  1'b1, mk(7'h01, 3'd3, 7'h33), 32'h10C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
    check("mulhu.expectFE", 64'(EX_alu_result), 64'hFFFF_FFFE);
    run_op("div0",   1'b1, mk(7'h01, 3'd4, 7'h33), 32'h110, 32'd7, 32'd0, 32'd0, 1'b1);
    run_op("removf", 1'b1, mk(7'h01, 3'd6, 7'h33), 32'h114, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run_op("divu",   1'b1, mk(7'h01, 3'd5, 7'h33), 32'h118, 32'd100, 32'd7, 32'd0, 1'b1);
    run_op("bubble", 1'b0, mk(7'h00, 3'd0, 7'h33), 32'h11C, 32'd1, 32'd2, 32'd0, 1'b1);
    run_op("unknown",1'b1, mk(7'h00, 3'd0, 7'h7F), 32'h120, 32'd1, 32'd2, 32'd3, 1'b1);
    run_op("branch", 1'b1, mk(7'h00, 3'd0, 7'h63), 32'h124, 32'd1, 32'd2, 32'd3, 1'b1);

    // Reset while the multiplier is busy
    @(negedge clk);
    present(1'b1, mk(7'h01, 3'd0, 7'h33), 32'h200, 32'd9, 32'd9, 32'd0, 1'b1);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst.stall",  64'(ex_stall),      64'd0);
    check("midrst.result", 64'(EX_alu_result), 64'd0);
    check("midrst.rw",     64'(EX_regwrite),   64'd0);
    @(negedge clk);
    present(1'b1, mk(7'h00, 3'd0, 7'h33), 32'h204, 32'd1, 32'd2, 32'd0, 1'b1);
    reset = 1'b0;
    run_op("add_after_rst", 1'b1, mk(7'h00, 3'd0, 7'h33), 32'h204, 32'd20, 32'd22, 32'd0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      logic [6:0]  op;
      logic [6:0]  f7 = 7'($urandom);
      logic        v = 1'b1;
      case ($urandom_range(0, 11))
        0: begin v = 1'b0; op = 7'h33; end
        1: op = 7'h7F;
        2: begin op = 7'h33; f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
        3: op = 7'h13;
        4: op = 7'h03;
        5: op = 7'h23;
        6: op = 7'h37;
        7: op = 7'h17;
        8: op = 7'h6F;
        9: op = 7'h67;
        10: op = 7'h63;
        default: begin op = 7'h33; f7 = 7'h01; end
      endcase
      run_op($sformatf("rnd%0d", i), v, mk(f7, 3'($urandom), op), $urandom(), pick(), pick(),
             pick(), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
